game_engine_n: RTL and testbench

- Parametrised successor to the 4-card arithmetic-game controller. Holds N_CARDS operands, accepts keypad key strobes (operand / operator / undo), merges two cards per move, and flags win/lose against TARGET.
- Adds multi-level undo, rejection of illegal moves, and explicit win/lose outputs.
- Sits between the keypad decoder and the display driver; the deal comes from the random-number block.

---
 rtl/game_pkg.sv | 30 +++
 rtl/game_alu.sv | 59 +++++
 rtl/game_engine_n.sv | 257 +++++++++++++++++++++++++
 tb/tb_game_engine_n.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the card arithmetic game engine.
package game_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A,
    S_OP,
    S_B,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [3:0] KEY_OP_BASE = 4'd10;
  localparam logic [3:0] KEY_UNDO    = 4'd14;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/game_alu.sv
// Combinational move evaluator: result of a op b plus a reject flag for illegal moves.
// With GAME_EXACT_DIV_EN defined, divisions leaving a remainder are rejected.
module game_alu
  import game_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             reject
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   b_nz;
  logic [WIDTH-1:0]   quot;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  // Substitute a divisor of 1 so the divider never sees zero; the move is rejected anyway.
  assign b_nz = (b == '0) ? WIDTH'(1) : b;
  assign quot = a / b_nz;

`ifdef GAME_EXACT_DIV_EN
  logic [WIDTH-1:0] rem;
  assign rem = a % b_nz;
`endif

  always_comb begin
    result = '0;
    reject = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        reject = sum[WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        reject = (a < b);
      end
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        reject = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      OP_DIV: begin
        result = quot;
`ifdef GAME_EXACT_DIV_EN
        reject = (b == '0) || (rem != '0);
`else
        reject = (b == '0);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/game_engine_n.sv
// N-card arithmetic game controller: keypad-driven merges, multi-level undo, win/lose flags.
// Optional build macro GAME_EXACT_DIV_EN (see game_alu) rejects inexact divisions.
module game_engine_n
  import game_pkg::*;
#(
  parameter int N_CARDS = 4,
  parameter int WIDTH   = 10,
  parameter int TARGET  = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       restart,
  input  logic                       key_valid,
  input  logic [3:0]                 key_code,
  input  logic [N_CARDS*WIDTH-1:0]   deal_i,
  output logic [N_CARDS*WIDTH-1:0]   num_o,
  output logic [N_CARDS-1:0]         valid_o,
  output logic [$clog2(N_CARDS):0]   sel_o,
  output logic [1:0]                 op_o,
  output logic                       win_o,
  output logic                       lose_o,
  output logic                       err_o
);

  localparam int IW = $clog2(N_CARDS);
  localparam logic [3:0]       NK  = 4'(N_CARDS);
  localparam logic [WIDTH-1:0] TGT = WIDTH'(TARGET);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] num_reg   [N_CARDS];
  logic [WIDTH-1:0] saved_reg [N_CARDS];
  logic             valid_reg [N_CARDS];
  logic [N_CARDS-1:0] valid_vec;
  logic [7:0]       valid8;

  logic [IW-1:0] a_idx_reg, b_idx_reg, sp_reg, top_idx;
  logic          sel_reg, win_reg, lose_reg, err_reg;
  logic          start_prev_reg, restart_prev_reg;
  op_t           op_reg;

  logic [IW-1:0]    stk_lo     [N_CARDS-1];
  logic [IW-1:0]    stk_hi     [N_CARDS-1];
  logic [WIDTH-1:0] stk_lo_val [N_CARDS-1];
  logic [WIDTH-1:0] stk_hi_val [N_CARDS-1];

  logic start_edge, restart_edge, key_act;
  logic card_key, op_key, undo_key;
  logic [IW-1:0] card_idx, lo_idx, hi_idx;
  op_t key_op;
  logic [WIDTH-1:0] alu_result;
  logic alu_reject, game_over;
  logic do_sel_a, do_sel_b, do_op, do_clear_sel, do_pop, do_err, do_commit;

  assign start_edge   = start & ~start_prev_reg;
  assign restart_edge = restart & ~restart_prev_reg & (state_reg != S_IDLE);
  assign key_act      = key_valid & ~start_edge & ~restart_edge;

  assign card_idx = IW'(key_code - 4'd1);
  assign card_key = key_act && (key_code != 4'd0) && (key_code <= NK) && valid_vec[card_idx];
  assign op_key   = key_act && (key_code >= KEY_OP_BASE) && (key_code < KEY_UNDO);
  assign undo_key = key_act && (key_code == KEY_UNDO);
  // Codes 10..13 map to ADD..DIV; their low two bits minus 2 (mod 4) give the enum value.
  assign key_op   = op_t'(key_code[1:0] - 2'd2);

  assign lo_idx  = (a_idx_reg < b_idx_reg) ? a_idx_reg : b_idx_reg;
  assign hi_idx  = (a_idx_reg < b_idx_reg) ? b_idx_reg : a_idx_reg;
  assign top_idx = sp_reg - IW'(1);

  always_comb begin
    valid8 = '0;
    valid8[N_CARDS-1:0] = valid_vec;
  end
  // Two cards alive before a successful merge means one survives after it.
  assign game_over = (popcount8(valid8) == 4'd2);

  game_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (num_reg[a_idx_reg]),
    .b      (num_reg[b_idx_reg]),
    .op     (op_reg),
    .result (alu_result),
    .reject (alu_reject)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    do_sel_a     = 1'b0;
    do_sel_b     = 1'b0;
    do_op        = 1'b0;
    do_clear_sel = 1'b0;
    do_pop       = 1'b0;
    do_err       = 1'b0;
    do_commit    = 1'b0;
    if (start_edge || restart_edge) begin
      state_next = S_A;
    end else begin
      case (state_reg)
        S_A: begin
          if (card_key) begin
            do_sel_a   = 1'b1;
            state_next = S_OP;
          end else if (undo_key) begin
            if (sp_reg == '0) do_err = 1'b1;
            else              do_pop = 1'b1;
          end
        end
        S_OP: begin
          if (card_key) begin
            do_sel_a = 1'b1;
          end else if (op_key) begin
            do_op      = 1'b1;
            state_next = S_B;
          end else if (undo_key) begin
            do_clear_sel = 1'b1;
            state_next   = S_A;
          end
        end
        S_B: begin
          if (op_key) begin
            do_op = 1'b1;
          end else if (card_key && (card_idx != a_idx_reg)) begin
            do_sel_b   = 1'b1;
            state_next = S_EXEC;
          end else if (undo_key) begin
            do_clear_sel = 1'b1;
            state_next   = S_A;
          end
        end
        S_EXEC: begin
          do_clear_sel = 1'b1;
          if (alu_reject) begin
            do_err     = 1'b1;
            state_next = S_A;
          end else begin
            do_commit  = 1'b1;
            state_next = game_over ? S_DONE : S_A;
          end
        end
        S_DONE: begin
          if (undo_key) begin
            if (sp_reg == '0) begin
              do_err = 1'b1;
            end else begin
              do_pop     = 1'b1;
              state_next = S_A;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_o  = {sel_reg, a_idx_reg};
    op_o   = op_reg;
    win_o  = win_reg;
    lose_o = lose_reg;
    err_o  = err_reg;
  end

  generate
    for (genvar gi = 0; gi < N_CARDS; gi++) begin : g_card
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          num_reg[gi]   <= '0;
          saved_reg[gi] <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (start_edge) begin
          num_reg[gi]   <= deal_i[gi*WIDTH +: WIDTH];
          saved_reg[gi] <= deal_i[gi*WIDTH +: WIDTH];
          valid_reg[gi] <= 1'b1;
        end else if (restart_edge) begin
          num_reg[gi]   <= saved_reg[gi];
          valid_reg[gi] <= 1'b1;
        end else if (do_commit) begin
          if (lo_idx == IW'(gi)) num_reg[gi]   <= alu_result;
          if (hi_idx == IW'(gi)) valid_reg[gi] <= 1'b0;
        end else if (do_pop) begin
          if (stk_lo[top_idx] == IW'(gi)) num_reg[gi] <= stk_lo_val[top_idx];
          if (stk_hi[top_idx] == IW'(gi)) begin
            num_reg[gi]   <= stk_hi_val[top_idx];
            valid_reg[gi] <= 1'b1;
          end
        end
      end
      assign num_o[gi*WIDTH +: WIDTH] = num_reg[gi];
      assign valid_vec[gi]            = valid_reg[gi];
    end
  endgenerate

  assign valid_o = valid_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev_reg   <= 1'b0;
      restart_prev_reg <= 1'b0;
      a_idx_reg        <= '0;
      b_idx_reg        <= '0;
      sel_reg          <= 1'b0;
      op_reg           <= OP_ADD;
      sp_reg           <= '0;
      win_reg          <= 1'b0;
      lose_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      start_prev_reg   <= start;
      restart_prev_reg <= restart;
      err_reg          <= do_err;
      if (start_edge || restart_edge) begin
        a_idx_reg <= '0;
        sel_reg   <= 1'b0;
        op_reg    <= OP_ADD;
        sp_reg    <= '0;
        win_reg   <= 1'b0;
        lose_reg  <= 1'b0;
      end else begin
        if (do_sel_a) begin
          a_idx_reg <= card_idx;
          sel_reg   <= 1'b1;
        end
        if (do_sel_b)     b_idx_reg <= card_idx;
        if (do_op)        op_reg    <= key_op;
        if (do_clear_sel) sel_reg   <= 1'b0;
        if (do_commit) begin
          sp_reg <= sp_reg + IW'(1);
          if (game_over) begin
            win_reg  <= (alu_result == TGT);
            lose_reg <= (alu_result != TGT);
          end
        end
        if (do_pop) begin
          sp_reg   <= top_idx;
          win_reg  <= 1'b0;
          lose_reg <= 1'b0;
        end
      end
    end
  end

  // Undo history holds only state overwritten by a merge; sp_reg alone defines emptiness.
  always_ff @(posedge clk) begin
    if (do_commit) begin
      stk_lo[sp_reg]     <= lo_idx;
      stk_hi[sp_reg]     <= hi_idx;
      stk_lo_val[sp_reg] <= num_reg[lo_idx];
      stk_hi_val[sp_reg] <= num_reg[hi_idx];
    end
  end

endmodule

// File: tb/tb_game_engine_n.sv
// Scoreboard bench for game_engine_n: directed key sequences push expected output events,
// a negedge monitor pops one per observed change or error pulse.
module tb_game_engine_n;

  logic        clk = 1'b0;
  logic        rst, start, restart, key_valid;
  logic [3:0]  key_code;
  logic [39:0] deal_i;
  logic [39:0] num_o;
  logic [3:0]  valid_o;
  logic [2:0]  sel_o;
  logic [1:0]  op_o;
  logic        win_o, lose_o, err_o;

  int compared = 0;
  int failed   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    string       name;
    logic [39:0] num;
    logic [3:0]  valid;
    logic        win, lose, err, sel;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  game_engine_n #(.N_CARDS(4), .WIDTH(10), .TARGET(24)) dut (
    .clk(clk), .rst(rst), .start(start), .restart(restart),
    .key_valid(key_valid), .key_code(key_code), .deal_i(deal_i),
    .num_o(num_o), .valid_o(valid_o), .sel_o(sel_o), .op_o(op_o),
    .win_o(win_o), .lose_o(lose_o), .err_o(err_o)
  );

  function automatic logic [39:0] cards(input int c0, c1, c2, c3);
    return {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
  endfunction

  function automatic void ex(input string n, input logic [39:0] num, input logic [3:0] v,
                             input logic w, input logic l, input logic e, input logic s);
    exp_t t;
    t.name = n; t.num = num; t.valid = v; t.win = w; t.lose = l; t.err = e; t.sel = s;
    q.push_back(t);
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end else begin
      $display("ok   %s = %h", n, act);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic deal(input logic [39:0] d);
    deal_i = d;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic replay();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: any visible change (or an err pulse) is one DUT transaction.
  initial begin
    logic [46:0] prev, cur;
    exp_t e;
    prev = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      cur = {num_o, valid_o, win_o, lose_o, sel_o[2]};
      if (err_o || cur != prev) begin
        compared++;
        if (q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_event: got num=%h valid=%b win=%b lose=%b err=%b sel=%b required none",
                   num_o, valid_o, win_o, lose_o, err_o, sel_o[2]);
        end else begin
          e = q.pop_front();
          if ({num_o, valid_o, win_o, lose_o, err_o, sel_o[2]} !==
              {e.num, e.valid, e.win, e.lose, e.err, e.sel}) begin
            failed++;
            $display("FAIL %s: got num=%h valid=%b win=%b lose=%b err=%b sel=%b required num=%h valid=%b win=%b lose=%b err=%b sel=%b",
                     e.name, num_o, valid_o, win_o, lose_o, err_o, sel_o[2],
                     e.num, e.valid, e.win, e.lose, e.err, e.sel);
          end else begin
            $display("ok   %s num=%h valid=%b win=%b lose=%b err=%b", e.name,
                     num_o, valid_o, win_o, lose_o, err_o);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    logic [39:0] d1, d2, d3, d4, d5, d6;
    d1 = cards(1, 2, 3, 4);
    d2 = cards(5, 0, 7, 9);
    d3 = cards(40, 30, 1, 1);
    d4 = cards(7, 2, 1, 1);
    d5 = cards(9, 8, 7, 6);
    d6 = cards(6, 6, 6, 6);

    rst = 1'b1; start = 1'b0; restart = 1'b0; key_valid = 1'b0; key_code = 4'd0; deal_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_num",   64'(num_o),   64'd0);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_sel",   64'(sel_o),   64'd0);
    chk("reset_op",    64'(op_o),    64'd0);
    chk("reset_win",   64'(win_o),   64'd0);
    chk("reset_lose",  64'(lose_o),  64'd0);
    chk("reset_err",   64'(err_o),   64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Keys in IDLE and restart in IDLE do nothing.
    press(4'd1);
    replay();

    // Win: 1*2, 2*3, 6*4 = 24.
    ex("win_deal", d1, 4'b1111, 0, 0, 0, 0);       deal(d1);
    ex("win_selA1", d1, 4'b1111, 0, 0, 0, 1);      press(4'd1);
    press(4'd12);
    ex("win_mv1", cards(2, 2, 3, 4), 4'b1101, 0, 0, 0, 0); press(4'd2);
    press(4'd2);   // card 2 no longer in play
    ex("win_selA2", cards(2, 2, 3, 4), 4'b1101, 0, 0, 0, 1); press(4'd1);
    press(4'd12);
    ex("win_mv2", cards(6, 2, 3, 4), 4'b1001, 0, 0, 0, 0); press(4'd3);
    ex("win_selA3", cards(6, 2, 3, 4), 4'b1001, 0, 0, 0, 1); press(4'd1);
    press(4'd12);
    ex("win_mv3", cards(24, 2, 3, 4), 4'b0001, 1, 0, 0, 0); press(4'd4);
    chk("win_op_held", 64'(op_o), 64'd2);

    // Undo back to the deal, then one too many.
    ex("undo1", cards(6, 2, 3, 4), 4'b1001, 0, 0, 0, 0);  press(4'd14);
    ex("undo2", cards(2, 2, 3, 4), 4'b1101, 0, 0, 0, 0);  press(4'd14);
    ex("undo3", d1, 4'b1111, 0, 0, 0, 0);                 press(4'd14);
    ex("undo_empty", d1, 4'b1111, 0, 0, 1, 0);            press(4'd14);

    // Divide by zero.
    ex("dz_deal", d2, 4'b1111, 0, 0, 0, 0);   deal(d2);
    ex("dz_selA", d2, 4'b1111, 0, 0, 0, 1);   press(4'd1);
    press(4'd13);
    ex("dz_reject", d2, 4'b1111, 0, 0, 1, 0); press(4'd2);

    // Overflow 40*30, then 40+30, then restart.
    ex("ov_deal", d3, 4'b1111, 0, 0, 0, 0);   deal(d3);
    ex("ov_selA", d3, 4'b1111, 0, 0, 0, 1);   press(4'd1);
    press(4'd12);
    ex("ov_reject", d3, 4'b1111, 0, 0, 1, 0); press(4'd2);
    ex("add_selA", d3, 4'b1111, 0, 0, 0, 1);  press(4'd1);
    press(4'd10);
    press(4'd1);   // B equal to A is ignored
    ex("add_mv", cards(70, 30, 1, 1), 4'b1101, 0, 0, 0, 0); press(4'd2);
    press(4'd2);   // dead card
    press(4'd15);  // unused code
    ex("restart", d3, 4'b1111, 0, 0, 0, 0);   replay();

    // Division 7/2.
    ex("div_deal", d4, 4'b1111, 0, 0, 0, 0);  deal(d4);
    ex("div_selA", d4, 4'b1111, 0, 0, 0, 1);  press(4'd1);
    press(4'd13);
`ifdef GAME_EXACT_DIV_EN
    ex("div_inexact", d4, 4'b1111, 0, 0, 1, 0);
`else
    ex("div_floor", cards(3, 2, 1, 1), 4'b1101, 0, 0, 0, 0);
`endif
    press(4'd2);

    // Start + restart + key in one cycle while in S_B.
    ex("pr_deal", d5, 4'b1111, 0, 0, 0, 0);   deal(d5);
    ex("pr_selA", d5, 4'b1111, 0, 0, 0, 1);   press(4'd1);
    press(4'd10);
    ex("pr_mv", cards(17, 8, 7, 6), 4'b1101, 0, 0, 0, 0); press(4'd2);
    ex("pr_selA2", cards(17, 8, 7, 6), 4'b1101, 0, 0, 0, 1); press(4'd1);
    press(4'd11);
    ex("pr_newdeal", d6, 4'b1111, 0, 0, 0, 0);
    deal_i = d6; start = 1'b1; restart = 1'b1; key_valid = 1'b1; key_code = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; restart = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    @(posedge clk); #1;
    chk("pr_op_cleared", 64'(op_o), 64'd0);
    ex("pr_stack_clear", d6, 4'b1111, 0, 0, 1, 0); press(4'd14);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    if (q.size() != 0) begin
      compared++;
      failed++;
      $display("FAIL timeout: %0d expected events outstanding, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
